// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: widths, the NOP
// encoding, branch opcodes and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h1000;
  localparam logic [3:0]         OPC_JNZ   = 4'b1000;
  localparam logic [3:0]         OPC_JMP   = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  // Major opcode field of an instruction word.
  function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1:INSTR_W-4];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register. Priority: clear > load > increment > hold.
// The increment wraps 0xFF -> 0x00 silently.
module fetch_pc_reg
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_clr,
  input  logic            pc_load,
  input  logic [PC_W-1:0] load_addr,
  input  logic            pc_inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // Next-PC selection.
  always_comb begin
    pc_d = pc_q;
    if (pc_clr) begin
      pc_d = '0;
    end else if (pc_load) begin
      pc_d = load_addr;
    end else if (pc_inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // PC storage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch FSM, PC, IF/ID pipeline register and a
// saturating count of delivered instructions.
// Optional build macro FETCH_JMP_PREDECODE_EN: resolve unconditional JMP
// directly in fetch instead of waiting for a REDIRECT from execute.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | not fetching; PC at 0, IF/ID holds a NOP bubble
// ST_RUN  | fetching one instruction per cycle
// ST_HOLD | frozen by STALL; PC and IF/ID keep their values
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_addr,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic [15:0]        fetch_cnt
);

  fetch_state_t       state_d, state_q;
  logic [INSTR_W-1:0] ifid_instr_d, ifid_instr_q;
  logic [PC_W-1:0]    ifid_pc_d, ifid_pc_q;
  logic               ifid_valid_d, ifid_valid_q;
  logic [15:0]        fetch_cnt_d, fetch_cnt_q;

  logic            pc_clr;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_addr;
  logic            pc_inc;
  logic [PC_W-1:0] pc;
  logic            jmp_hit;

`ifdef FETCH_JMP_PREDECODE_EN
  assign jmp_hit = (opcode(rom_data) == OPC_JMP);
`else
  assign jmp_hit = 1'b0;
`endif

  // Next state, PC control and IF/ID contents for this edge.
  // Bubbles (NOP, VALID=0) keep the previous IFID_PC.
  always_comb begin
    state_d      = state_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    fetch_cnt_d  = fetch_cnt_q;
    pc_clr       = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = redirect_addr;
    pc_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (stop) begin
          state_d      = ST_IDLE;
          pc_clr       = 1'b1;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (redirect) begin
          state_d      = ST_RUN;
          pc_load      = 1'b1;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (stall) begin
          state_d = ST_HOLD;
        end else if (jmp_hit) begin
          state_d      = ST_RUN;
          pc_load      = 1'b1;
          pc_load_addr = rom_data[PC_W-1:0];
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else begin
          state_d      = ST_RUN;
          pc_inc       = 1'b1;
          ifid_instr_d = rom_data;
          ifid_pc_d    = pc;
          ifid_valid_d = 1'b1;
          if (fetch_cnt_q != 16'hFFFF) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  fetch_pc_reg u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_clr    (pc_clr),
    .pc_load   (pc_load),
    .load_addr (pc_load_addr),
    .pc_inc    (pc_inc),
    .pc        (pc)
  );

  assign rom_addr   = pc;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stimulus against
// a cycle-level behavioural model of the fetch stage.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic        ifid_valid;
  logic [15:0] fetch_cnt;

  logic [15:0] rom [256];

  int n_checks;
  int n_errors;

  // Reference model: mode 0 idle, 1 running, 2 held.
  int          m_mode;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic [7:0]  m_ipc;
  logic        m_valid;
  logic [15:0] m_cnt;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_valid    (ifid_valid),
    .fetch_cnt     (fetch_cnt)
  );

  assign rom_data = rom[rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 8'h00;
    m_instr = 16'h1000;
    m_ipc   = 8'h00;
    m_valid = 1'b0;
    m_cnt   = 16'h0000;
  endtask

  task automatic chk_reset_values();
    chk("rst_rom_addr", rom_addr, 8'h00);
    chk("rst_instr", ifid_instr, 16'h1000);
    chk("rst_ifid_pc", ifid_pc, 8'h00);
    chk("rst_valid", ifid_valid, 1'b0);
    chk("rst_cnt", fetch_cnt, 16'h0000);
  endtask

  task automatic chk_model();
    chk("rom_addr", rom_addr, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_valid", ifid_valid, m_valid);
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  // Drive inputs for one cycle, predict the edge, then compare after it.
  task automatic step(input logic s, input logic p, input logic st,
                      input logic rd, input logic [7:0] ra);
    int          n_mode;
    logic [7:0]  n_pc;
    logic [15:0] n_instr;
    logic [7:0]  n_ipc;
    logic        n_valid;
    logic [15:0] n_cnt;
    logic [15:0] word;
    bit          jmp_early;
    start = s; stop = p; stall = st; redirect = rd; redirect_addr = ra;
    n_mode = m_mode; n_pc = m_pc; n_instr = m_instr;
    n_ipc = m_ipc; n_valid = m_valid; n_cnt = m_cnt;
    word = rom[m_pc];
`ifdef FETCH_JMP_PREDECODE_EN
    jmp_early = (word[15:12] == 4'b1001);
`else
    jmp_early = 1'b0;
`endif
    if (m_mode == 0) begin
      if (s) n_mode = 1;
    end else if (p) begin
      n_mode = 0; n_pc = 8'h00; n_instr = 16'h1000; n_valid = 1'b0;
    end else if (rd) begin
      n_mode = 1; n_pc = ra; n_instr = 16'h1000; n_valid = 1'b0;
    end else if (st) begin
      n_mode = 2;
    end else if (jmp_early) begin
      n_mode = 1; n_pc = word[7:0]; n_instr = 16'h1000; n_valid = 1'b0;
    end else begin
      n_mode  = 1;
      n_instr = word;
      n_ipc   = m_pc;
      n_valid = 1'b1;
      n_pc    = 8'((int'(m_pc) + 1) % 256);
      if (m_cnt < 16'hFFFF) n_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    m_mode = n_mode; m_pc = n_pc; m_instr = n_instr;
    m_ipc = n_ipc; m_valid = n_valid; m_cnt = n_cnt;
    #1;
    chk_model();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    model_reset();
    start = 1'b0; stop = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_model();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_addr = 8'h00;
    model_reset();
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    for (int i = 0; i < 16; i++) rom[i] = 16'h2000 | 16'(i);
    rom[8'h00] = 16'h3102;
    rom[8'h01] = 16'h3205;
    rom[8'h02] = 16'h3306;
    rom[8'h05] = 16'h1413;
    rom[8'h0C] = 16'h1112;
    rom[8'h0D] = 16'h9000;

    #12;
    chk_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle ignores stall and redirect; release alone does not start fetching.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
    chk("idle_rom_addr", rom_addr, 8'h00);
    chk("idle_valid", ifid_valid, 1'b0);

    // Straight-line fetch of the first three words.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("seq0_pc", ifid_pc, 8'h00);
    chk("seq0_instr", ifid_instr, 16'h3102);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("seq1_pc", ifid_pc, 8'h01);
    chk("seq1_instr", ifid_instr, 16'h3205);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("seq2_pc", ifid_pc, 8'h02);
    chk("seq2_instr", ifid_instr, 16'h3306);
    chk("seq_cnt", fetch_cnt, 16'd3);

    // Stall at PC 0x06.
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("pre_stall_addr", rom_addr, 8'h06);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("stall_instr", ifid_instr, 16'h1413);
      chk("stall_pc", ifid_pc, 8'h05);
      chk("stall_cnt", fetch_cnt, 16'd6);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("unstall_pc", ifid_pc, 8'h06);
    chk("unstall_cnt", fetch_cnt, 16'd7);

    // Redirect beats a simultaneous stall.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h0C);
    chk("redir_valid", ifid_valid, 1'b0);
    chk("redir_addr", rom_addr, 8'h0C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("redir_instr", ifid_instr, 16'h1112);

    // JMP word at PC 0x0D.
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef FETCH_JMP_PREDECODE_EN
    chk("jmp_pc", rom_addr, 8'h00);
    chk("jmp_valid", ifid_valid, 1'b0);
`else
    chk("jmp_instr", ifid_instr, 16'h9000);
    chk("jmp_valid", ifid_valid, 1'b1);
    chk("jmp_pc", rom_addr, 8'h0E);
`endif

    // START while running is ignored; STOP returns to idle at PC 0.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("start_in_run_valid", ifid_valid, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h40);
    chk("stop_addr", rom_addr, 8'h00);
    chk("stop_valid", ifid_valid, 1'b0);

    // Asynchronous reset in the middle of a run.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("post_rst_idle", ifid_valid, 1'b0);

    // Randomized control traffic over a random program.
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 2),
           1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 5),
           8'($urandom));
    end

    // Long straight run: PC wrap and counter saturation.
    for (int i = 0; i < 256; i++) begin
      if (rom[i][15:12] == 4'b1001) rom[i][15:12] = 4'b0011;
    end
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 65600; i++) begin
      if (m_pc == 8'hFF) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("pc_wrap", rom_addr, 8'h00);
      end else begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      end
    end
    chk("cnt_saturated", fetch_cnt, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("cnt_stays_sat", fetch_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
